// File: rtl/table_loader.sv
// Streams table entries from a valid/ready input into a RAM write port, addresses 0..DEPTH-1.
// Define TABLE_LOADER_CKSUM_EN to build the running checksum of written entries; otherwise cksum is 0.
module table_loader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       s_valid,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       s_ready,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [WIDTH-1:0]           wr_data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           cksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] ptr;
  logic          handshake;
  logic          accept;
  logic          begin_load;

  assign s_ready    = (state == LOAD);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign handshake  = s_valid && s_ready;
  // An entry offered in the abort cycle is dropped.
  assign accept     = handshake && !abort;
  assign begin_load = (state == IDLE) && start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (abort)                      state_next = IDLE;
        else if (handshake && ptr == LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (begin_load) begin
        ptr   <= '0;
        count <= '0;
      end else if (accept) begin
        wr_addr <= ptr;
        wr_data <= s_data;
        count   <= count + CW'(1);
        // The final handshake moves the FSM to DONE; the pointer parks at LAST.
        if (ptr != LAST) ptr <= ptr + AW'(1);
      end
    end
  end

`ifdef TABLE_LOADER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)             cksum <= '0;
    else if (begin_load) cksum <= '0;
    else if (accept)     cksum <= cksum + s_data;
  end
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_table_loader.sv
// Self-checking bench for table_loader: directed scenarios then random stimulus,
// compared every cycle against a transaction-level model of the loader.
module tb_table_loader;

  localparam int W = 8;
  localparam int D = 5;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic [W-1:0]  cksum;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, 1 = accepting entries, 2 = the single completion cycle.
  int phase = 0;
  int e_written = 0;
  int e_sum = 0;
  int e_wr_en = 0;
  int e_addr = 0;
  int e_data = 0;
  int done_seen = 0;

  table_loader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .count(count), .cksum(cksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model(input logic r, input logic st, input logic ab, input logic v,
                       input logic [W-1:0] d);
    if (r) begin
      phase = 0; e_written = 0; e_sum = 0; e_wr_en = 0; e_addr = 0; e_data = 0;
    end else begin
      e_wr_en = 0;
      case (phase)
        0: if (st) begin phase = 1; e_written = 0; e_sum = 0; end
        1: begin
          if (ab) phase = 0;
          else if (v) begin
            e_wr_en = 1;
            e_addr = e_written;
            e_data = int'(d);
            e_written++;
            e_sum = (e_sum + int'(d)) % 256;
            if (e_written == D) phase = 2;
          end
        end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic compare();
    int exp_ck;
`ifdef TABLE_LOADER_CKSUM_EN
    exp_ck = e_sum;
`else
    exp_ck = 0;
`endif
    check("s_ready", 32'(s_ready), 32'(phase == 1));
    check("busy",    32'(busy),    32'(phase != 0));
    check("done",    32'(done),    32'(phase == 2));
    check("wr_en",   32'(wr_en),   32'(e_wr_en));
    check("wr_addr", 32'(wr_addr), 32'(e_addr));
    check("wr_data", 32'(wr_data), 32'(e_data));
    check("count",   32'(count),   32'(e_written));
    check("cksum",   32'(cksum),   32'(exp_ck));
    if (phase == 2) done_seen++;
  endtask

  task automatic step(input logic r, input logic st, input logic ab, input logic v,
                      input logic [W-1:0] d);
    rst = r; start = st; abort = ab; s_valid = v; s_data = d;
    @(posedge clk);
    model(r, st, ab, v, d);
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [6:0] gaps;
    gaps = 7'b1011001;  // pattern 1,0,0,1,1,0,1 read from bit 0 upward

    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h33);  // abort and data in IDLE are ignored

    // Full load of 0xFF entries, with extra starts while busy.
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < D; i++) step(0, (i == 2), 0, 1, 8'hFF);
    step(0, 1, 1, 1, 8'h11);  // DONE cycle: start and abort ignored
    check("full_load_done_once", 32'(done_seen), 32'd1);
    step(0, 0, 0, 0, 8'h00);

    // Backpressure and gaps.
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) step(0, 0, 0, gaps[i], 8'(8'h40 + i));
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Abort mid-load with a valid entry in the abort cycle.
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'(8'h80 + i));
    step(0, 0, 1, 1, 8'h99);
    step(0, 0, 0, 1, 8'h9A);
    step(0, 0, 0, 0, 8'h00);

    // Reset mid-load.
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'(8'hC0 + i));
    step(1, 0, 0, 1, 8'hC3);
    step(0, 0, 0, 1, 8'hC4);
    step(0, 0, 0, 0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7),
           W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
